sca_feature_extractor: RTL and testbench

- Producer side of the fuzzy side-channel attack detector interface: consumes a stream of power-trace samples, each with a companion data-bus word.
- Reduces every fixed window of samples to the four detector features: energy, peak_power, mean_power and hamming_dist.
- Presents each feature set on a registered valid/ready output toward the detector FSM.
- Backpressures the sample stream while a feature set is pending.

---
 rtl/sca_feature_pkg.sv | 16 +
 rtl/sca_feature_extractor_popcount.sv | 19 +
 rtl/sca_feature_extractor.sv | 114 +++++++++++
 tb/tb_sca_feature_extractor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sca_feature_pkg.sv
// Feature widths and state encoding shared by the feature extractor and the fuzzy detector FSM.
// Pure declarations: no latency, no flow control.
package sca_feature_pkg;

  localparam int ENERGY_W   = 10;
  localparam int PEAK_W     = 10;
  localparam int MEAN_W     = 10;
  localparam int HAM_W      = 8;
  localparam int ENERGY_MAX = 1023;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

endpackage

// File: rtl/sca_feature_extractor_popcount.sv
// Combinational population count of a W-bit word.
// Latency 0; no flow control.
module popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]               din,
  output logic [$clog2(W+1)-1:0]     cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/sca_feature_extractor.sv
// Reduces each window of 2^WIN_LOG2 power samples to energy/peak/mean/Hamming features.
// Latency 1 cycle after the last sample; s_ready is low while a feature set waits for feat_ready.
module sca_feature_extractor
  import sca_feature_pkg::*;
#(
  parameter int SAMPLE_W     = 8,
  parameter int DATA_W       = 16,
  parameter int WIN_LOG2     = 4,
  parameter int ENERGY_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_sample,
  input  logic [DATA_W-1:0]   s_data,
  output logic                feat_valid,
  input  logic                feat_ready,
  output logic [ENERGY_W-1:0] energy,
  output logic [PEAK_W-1:0]   peak_power,
  output logic [MEAN_W-1:0]   mean_power,
  output logic [HAM_W-1:0]    hamming_dist,
  output logic                energy_sat
);

  localparam int SUM_W = SAMPLE_W + WIN_LOG2;
  localparam int SQ_W  = 2 * SAMPLE_W + WIN_LOG2;
  localparam int PC_W  = $clog2(DATA_W + 1);

  state_t              state;
  logic [WIN_LOG2-1:0] count;
  logic [SUM_W-1:0]    sum, sum_nx, mean_full;
  logic [SQ_W-1:0]     sumsq, sumsq_nx, sq_shift;
  logic [SAMPLE_W-1:0] peak, peak_nx;
  logic [DATA_W-1:0]   last_word, prev_word, ham_in;
  logic [PC_W-1:0]     pc;
  logic                accept, sat;

  assign s_ready    = (state == S_ACC) && !rst;
  assign feat_valid = (state == S_OUT);
  assign accept     = s_valid && s_ready;

  // Next-accumulator values fold in the current sample so the final sample
  // of a window lands directly in the registered features.
  always_comb begin
    sum_nx    = sum + SUM_W'(s_sample);
    sumsq_nx  = sumsq + SQ_W'(s_sample) * SQ_W'(s_sample);
    peak_nx   = (s_sample > peak) ? s_sample : peak;
    sq_shift  = sumsq_nx >> ENERGY_SHIFT;
    mean_full = sum_nx >> WIN_LOG2;
    sat       = (sq_shift > SQ_W'(ENERGY_MAX));
    ham_in    = s_data ^ prev_word;
  end

  popcount #(.W(DATA_W)) u_popcount (
    .din (ham_in),
    .cnt (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_ACC;
      count        <= '0;
      sum          <= '0;
      sumsq        <= '0;
      peak         <= '0;
      last_word    <= '0;
      prev_word    <= '0;
      energy       <= '0;
      peak_power   <= '0;
      mean_power   <= '0;
      hamming_dist <= '0;
      energy_sat   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            count     <= count + WIN_LOG2'(1);
            sum       <= sum_nx;
            sumsq     <= sumsq_nx;
            peak      <= peak_nx;
            last_word <= s_data;
            if (count == '1) begin
              state        <= S_OUT;
              energy       <= sat ? ENERGY_W'(ENERGY_MAX) : ENERGY_W'(sq_shift);
              energy_sat   <= sat;
              peak_power   <= PEAK_W'(peak_nx);
              mean_power   <= MEAN_W'(mean_full);
              hamming_dist <= HAM_W'(pc);
            end
          end
        end
        S_OUT: begin
          if (feat_ready) begin
            state     <= S_ACC;
            count     <= '0;
            sum       <= '0;
            sumsq     <= '0;
            peak      <= '0;
            prev_word <= last_word;
          end
        end
        default: begin
          state <= S_ACC;
          count <= '0;
          sum   <= '0;
          sumsq <= '0;
          peak  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sca_feature_extractor.sv
// Scoreboard bench: window-level reference model feeds an expectation queue, a monitor checks DUT output.
module tb_sca_feature_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_sample = '0;
  logic [15:0] s_data = '0;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [9:0]  energy, peak_power, mean_power;
  logic [7:0]  hamming_dist;
  logic        energy_sat;

  always #5 clk = ~clk;

  sca_feature_extractor dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_sample     (s_sample),
    .s_data       (s_data),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .energy       (energy),
    .peak_power   (peak_power),
    .mean_power   (mean_power),
    .hamming_dist (hamming_dist),
    .energy_sat   (energy_sat)
  );

  typedef struct {
    int e;
    int p;
    int m;
    int h;
    int sat;
  } feat_t;

  feat_t exp_q[$];
  feat_t mon_f;
  int    win_s[$];
  int    last_d = 0;
  int    prev_d = 0;
  bit    m_out = 1'b0;
  bit    rnd_ready = 1'b0;
  int    total = 0;
  int    bad = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
    end
  endfunction

  // Reference model: collects whole windows and derives features arithmetically.
  task automatic model_accept(int smp, int d);
    win_s.push_back(smp);
    last_d = d;
    if (win_s.size() == 16) begin
      int    sum = 0;
      int    sq = 0;
      int    mx = 0;
      feat_t f;
      foreach (win_s[i]) begin
        sum += win_s[i];
        sq  += win_s[i] * win_s[i];
        if (win_s[i] > mx) mx = win_s[i];
      end
      f.e   = sq >> 8;
      f.sat = (f.e > 1023) ? 1 : 0;
      if (f.sat == 1) f.e = 1023;
      f.m   = sum >> 4;
      f.p   = mx;
      f.h   = $countones(last_d ^ prev_d);
      exp_q.push_back(f);
      prev_d = last_d;
      win_s.delete();
      m_out = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win_s.delete();
      exp_q.delete();
      prev_d = 0;
      last_d = 0;
      m_out  = 1'b0;
    end else if (!m_out) begin
      if (s_valid) model_accept(int'(s_sample), int'(s_data));
    end else if (feat_ready) begin
      m_out = 1'b0;
    end
  end

  // Monitor: handshake protocol and feature values, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("s_ready", 32'(s_ready), 32'(!m_out));
      check("feat_valid", 32'(feat_valid), 32'(m_out));
      if (feat_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_feat: feat_valid=1 with no expected feature set at %0t", $time);
        end else begin
          mon_f = exp_q[0];
          check("energy", 32'(energy), 32'(mon_f.e));
          check("energy_sat", 32'(energy_sat), 32'(mon_f.sat));
          check("peak_power", 32'(peak_power), 32'(mon_f.p));
          check("mean_power", 32'(mean_power), 32'(mon_f.m));
          check("hamming_dist", 32'(hamming_dist), 32'(mon_f.h));
          if (feat_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) feat_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(logic [7:0] smp, logic [15:0] d);
    int n = 0;
    s_valid  = 1'b1;
    s_sample = smp;
    s_data   = d;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n >= 200) begin
        check("send_timeout", 32'(s_ready), 32'(1));
        break;
      end
      step();
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    forever begin
      @(negedge clk);
      if (feat_valid) break;
      n++;
      if (n >= 100) begin
        check("feat_timeout", 32'(feat_valid), 32'(1));
        break;
      end
    end
  endtask

  task automatic wait_feat(int e, int p, int m, int h, int sat);
    wait_valid();
    check("dir_energy", 32'(energy), 32'(e));
    check("dir_peak", 32'(peak_power), 32'(p));
    check("dir_mean", 32'(mean_power), 32'(m));
    check("dir_ham", 32'(hamming_dist), 32'(h));
    check("dir_sat", 32'(energy_sat), 32'(sat));
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    feat_ready = 1'b1;
    step();
    feat_ready = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, 32'(feat_valid), 32'(0));
    check({tag, "_energy"}, 32'(energy), 32'(0));
    check({tag, "_peak"}, 32'(peak_power), 32'(0));
    check({tag, "_mean"}, 32'(mean_power), 32'(0));
    check({tag, "_ham"}, 32'(hamming_dist), 32'(0));
    check({tag, "_sat"}, 32'(energy_sat), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Constant window, then held for five cycles under backpressure.
    for (int i = 0; i < 16; i++) send(8'd32, 16'h00FF);
    wait_feat(64, 32, 32, 8, 0);
    idle(4);
    consume();

    // Saturating window.
    for (int i = 0; i < 16; i++) send(8'd255, 16'h00FF);
    wait_feat(1023, 255, 255, 0, 1);
    consume();

    // Peak and Hamming chaining across two windows.
    for (int i = 0; i < 15; i++) send(8'($urandom), 16'($urandom));
    send(8'($urandom), 16'h00FF);
    wait_valid();
    @(posedge clk);
    #1;
    consume();
    for (int i = 0; i < 15; i++) send(8'(i), 16'($urandom));
    send(8'd15, 16'hFF00);
    wait_feat(4, 15, 7, 16, 0);
    consume();

    // Gapped input with the detector always ready.
    feat_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) begin
        send(8'($urandom), 16'($urandom));
        step();
      end
    end
    idle(3);

    // Back-to-back stream with an always-ready detector, then random gaps and ready.
    for (int i = 0; i < 32; i++) send(8'($urandom), 16'($urandom));
    idle(3);
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(8'($urandom), 16'($urandom));
      idle($urandom_range(0, 2));
    end
    rnd_ready  = 1'b0;
    feat_ready = 1'b1;
    idle(20);
    feat_ready = 1'b0;
    check("drained", 32'(exp_q.size()), 32'(0));

    // Reset in the middle of a window.
    for (int i = 0; i < 7; i++) send(8'($urandom), 16'($urandom));
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(8'd10, 16'h1234);
    wait_feat(6, 10, 10, 5, 0);
    consume();

    // Reset while a feature set is pending.
    for (int i = 0; i < 16; i++) send(8'($urandom), 16'($urandom));
    wait_valid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("out_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 32'(1));
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
